// File: rtl/fp32_to_fixed32_pkg.sv
// fixed_pkg: shared widths, saturation constants and types for FP32 to S13.18 conversion
package fixed_pkg;
    localparam int FIX_W = 32;
    localparam int FRAC_W = 18;
    localparam int FP32_BIAS = 127;
    localparam logic [FIX_W-1:0] SAT_POS = {1'b0, {(FIX_W-1){1'b1}}};
    localparam logic [FIX_W-1:0] SAT_NEG = {1'b1, {(FIX_W-1){1'b0}}};
    typedef logic signed [FIX_W-1:0] fix_t;
    typedef enum logic [1:0] {NORM, ZERO, INF, NAN_C} fp_class_t;
endpackage

// File: rtl/fp32_to_fixed32_if.sv
// fp32_to_fixed32_if: valid/ready stream carrying an FP32 sample in and an S13.18 result out
interface fp32_to_fixed32_if;
    import fixed_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [31:0] x;
    logic out_valid;
    logic out_ready;
    fix_t y;
    logic ovf;
    logic nan;
    logic udf;
    modport master (output in_valid, x, out_ready, input in_ready, out_valid, y, ovf, nan, udf);
    modport slave (input in_valid, x, out_ready, output in_ready, out_valid, y, ovf, nan, udf);
endinterface

// File: rtl/fp32_to_fixed32_align_round.sv
// fp32_align_round: shifts the 24-bit significand into place and rounds to nearest even
module fp32_align_round
    import fixed_pkg::*;
#(
    parameter int MAG_W = FIX_W - 1
) (
    input  logic signed [9:0] shift,
    input  logic [23:0] sig,
    output logic [MAG_W-1:0] mag,
    output logic zero
);
    logic [MAG_W-1:0] left;
    logic [47:0] right;
    logic [9:0] rs;
    logic [23:0] q;
    logic guard;
    logic sticky;
    // Left shifts are exact; right shifts keep a guard bit and a sticky OR of everything below it.
    always_comb begin
        rs = -shift;
        left = MAG_W'(sig) << shift[4:0];
        right = {sig, 24'b0} >> rs;
        q = right[47:24];
        guard = right[23];
        sticky = |right[22:0];
        mag = !shift[9] ? left : (rs > 10'd24 ? '0 : MAG_W'(q) + MAG_W'(guard & (sticky | q[0])));
        zero = mag == '0;
    end
endmodule

// File: rtl/fp32_to_fixed32.sv
// fp32_to_fixed32: three-stage FP32 to S13.18 converter with a stall-everything valid/ready pipe
module fp32_to_fixed32
    import fixed_pkg::*;
#(
    parameter int FRAC_W = fixed_pkg::FRAC_W,
    parameter int FIX_W = fixed_pkg::FIX_W
) (
    input logic clock,
    input logic resetn,
    fp32_to_fixed32_if.slave bus
);
    localparam int MAG_W = FIX_W - 1;
    localparam int OVF_SH = MAG_W - 23;
    logic adv;
    logic v1, v2;
    logic [7:0] e;
    logic signed [9:0] sh;
    fp_class_t cls;
    logic ex;
    logic s1, ex1, den1;
    fp_class_t c1;
    logic signed [9:0] sh1;
    logic [23:0] m1;
    logic [MAG_W-1:0] mag;
    logic mag_zero;
    logic s2, ex2, den2, zero2;
    fp_class_t c2;
    logic [MAG_W-1:0] mag2;
    fix_t y_n;
    logic ovf_n, nan_n, udf_n;

    assign adv = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // Classify the incoming operand; -2^(MAG_W-FRAC_W) is the one value at the overflow exponent that fits.
    always_comb begin
        e = bus.x[30:23];
        sh = signed'({2'b00, e} - 10'(FP32_BIAS + 23 - FRAC_W));
        ex = bus.x[31] && bus.x[22:0] == '0 && sh == 10'(OVF_SH);
        cls = e == 8'hFF ? (bus.x[22:0] != '0 ? NAN_C : INF)
            : e == '0 ? ZERO
            : (!sh[9] && sh >= 10'(OVF_SH) && !ex) ? INF : NORM;
    end

    // Stage 1: hold sign, class, shift amount and significand of the accepted sample.
    always_ff @(posedge clock) begin
        if (adv) begin
            s1 <= bus.x[31];
            c1 <= cls;
            ex1 <= ex;
            den1 <= bus.x[22:0] != '0;
            sh1 <= sh;
            m1 <= {1'b1, bus.x[22:0]};
        end
    end

    fp32_align_round #(.MAG_W(MAG_W)) u_align (
        .shift(sh1),
        .sig(m1),
        .mag(mag),
        .zero(mag_zero)
    );

    // Stage 2: hold the rounded magnitude alongside the classification.
    always_ff @(posedge clock) begin
        if (adv) begin
            s2 <= s1;
            c2 <= c1;
            ex2 <= ex1;
            den2 <= den1;
            mag2 <= mag;
            zero2 <= mag_zero;
        end
    end

    // Apply sign or saturation and pick exactly one flag for the sample.
    always_comb begin
        y_n = '0;
        ovf_n = 1'b0;
        nan_n = 1'b0;
        udf_n = 1'b0;
        if (c2 == NAN_C) begin
            nan_n = 1'b1;
        end else if (c2 == INF) begin
            ovf_n = 1'b1;
            y_n = s2 ? SAT_NEG : SAT_POS;
        end else if (c2 == ZERO) begin
            udf_n = den2;
        end else if (ex2) begin
            y_n = SAT_NEG;
        end else begin
            y_n = s2 ? -fix_t'({1'b0, mag2}) : fix_t'({1'b0, mag2});
            udf_n = zero2;
        end
    end

    // Valid bits and the output register: reset clears them, and nothing moves unless adv.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.y <= '0;
            bus.ovf <= 1'b0;
            bus.nan <= 1'b0;
            bus.udf <= 1'b0;
        end else if (adv) begin
            v1 <= bus.in_valid;
            v2 <= v1;
            bus.out_valid <= v2;
            bus.y <= y_n;
            bus.ovf <= ovf_n;
            bus.nan <= nan_n;
            bus.udf <= udf_n;
        end
    end
endmodule

// File: doc/fp32_to_fixed32.md
# fp32_to_fixed32

Pipelined converter from IEEE-754 single precision to S13.18 two's-complement fixed point. It is the input-side counterpart of `fixed32_to_fp32`. It feeds fixed-point datapaths: interpolators, future sigmoid/exp cores, and table writers that store S13.18 words. A valid/ready handshake on both sides lets it sit between streaming producers and stalling consumers.

## Interface
- `FRAC_W`, default 18: fractional bits of the output.
- `FIX_W`, default 32: output width. Integer bits = `FIX_W`-1-`FRAC_W` = 13.
- `clock`  in  1: single clock, rising edge.
- `resetn`  in  1: reset, synchronous, active-low.
- `in_valid`  in  1: `x` carries a sample.
- `in_ready`  out  1: converter accepts a sample this cycle.
- `x`  in  32: FP32 operand.
- `out_valid`  out  1: `y` and flags are valid.
- `out_ready`  in  1: consumer takes the output this cycle.
- `y`  out  32: S13.18 two's-complement result.
- `ovf`  out  1: |x| ≥ 8192 or infinity; `y` is saturated.
- `nan`  out  1: the input was NaN; `y` = 0.
- `udf`  out  1: the input was nonzero, finite and not NaN, but `y` = 0 after rounding (this includes denormals).

## Operation
- Fields: s = x[31], e = x[30:23], m = x[22:0]. Significand M = {1, m} (24 bits).
- Value scaled to fixed point: |y| = M · 2^(e−132). For generic `FRAC_W` the exponent is (e − 127 − 23 + `FRAC_W`).
- Classification, in priority order:
  - e = 255 and m ≠ 0: NaN. `y` = 0, `nan` = 1.
  - e = 255 and m = 0: infinity. Saturate, `ovf` = 1.
  - e = 0: zero or denormal. `y` = 0. `udf` = 1 if m ≠ 0.
  - e ≥ 140: overflow. Saturate, `ovf` = 1. Exception: exactly −8192.0 (0xC6000000) yields 0x80000000 with `ovf` = 0.
  - 132 ≤ e ≤ 139: left shift by e−132. This is exact; the magnitude is at most 31 bits.
  - 107 ≤ e ≤ 131: right shift by 132−e. Round to nearest, ties to even, using guard plus sticky bits. Rounding cannot overflow 31 bits.
  - e ≤ 106: `y` = 0, `udf` = 1.
- Saturation values: positive 0x7FFFFFFF, negative 0x80000000.
- Sign application: `y` = s ? −mag : mag. The result −0 maps to 0x00000000.
- Only one of the three flags is set per sample. All flags are 0 for normal in-range results.

## Timing
- Three-stage pipeline:
  - S1: register `x`, classify, compute the shift amount.
  - S2: barrel shift, round, produce the 31-bit magnitude.
  - S3: negate, saturate, register `y` and the flags.
- Latency is 3 cycles from the accepting edge (`in_valid` & `in_ready`) to `out_valid`. Throughput is 1 sample per cycle.
- Global advance: adv = !out_valid | out_ready. `in_ready` = adv, driven combinationally from `out_ready` and `out_valid`.
- When adv = 0, every stage holds, including its valid bit. `y` and flags stay stable while `out_valid` & !`out_ready`.
- Bubbles: a stage valid bit goes to 0 when no sample enters. Bubbles are compressed only at S3 through adv, never in the middle of the pipe.
- Simultaneous output consume and input accept in the same cycle is legal and loses no data.
- Reset: all stage valid bits, `out_valid`, `y`, `ovf`, `nan` and `udf` reset to 0. `in_ready` = 1 in the first cycle after reset. Samples in flight when reset is asserted are discarded and never reach the output.
- Datapath registers other than the valid bits need no reset.

## Structure
- Package `fixed_pkg` holds:
  - `FIX_W`, `FRAC_W` and `FP32_BIAS` (127).
  - `SAT_POS`/`SAT_NEG` constants.
  - The S13.18 typedef.
  - A class enum {NORM, ZERO, INF, NAN_C}.
- Sub-module `fp32_align_round`: combinational shift plus round-to-nearest-even on the 24-bit significand. Inputs are the signed shift and M; outputs are the 31-bit magnitude and a zero indication. Instantiated in S2. The top module owns the handshake and the stage registers.

## Test plan
- Normal values, no stall:
  - 0x3F800000 (1.0) → 0x00040000.
  - 0xBFC00000 (−1.5) → 0xFFFA0000, flags 0.
  - Output appears exactly 3 cycles after acceptance.
- Saturation:
  - 0x46000000 (8192.0) → 0x7FFFFFFF, `ovf` = 1.
  - 0xFF800000 (−inf) → 0x80000000, `ovf` = 1.
  - 0xC6000000 → 0x80000000, `ovf` = 0.
- Special inputs:
  - 0x7FC00000 → 0, `nan` = 1.
  - 0x00000001 (denormal) → 0, `udf` = 1.
  - 0x80000000 (−0) → 0, all flags 0.
- Rounding:
  - 0x36000000 (2^−19, exact tie) → 0, `udf` = 1.
  - 0x36C00000 (1.5 LSB) → 0x00000002.
  - 0x36A00000 (1.25 LSB) → 0x00000001.
- Backpressure: stream 10 back-to-back samples with `out_ready` toggling randomly.
  - Outputs come in order with none lost or duplicated.
  - `y` is stable while stalled.
  - `in_ready` follows adv.
- Reset mid-stream: assert `resetn` = 0 for 1 cycle with 3 samples in flight.
  - `out_valid` = 0 next cycle.
  - None of the 3 samples emerges afterwards.
  - `in_ready` = 1.
